// File: rtl/max_unpool_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : max_unpool_pkg
//  Purpose  : Shared fp16 definitions for the 2x2 max-unpool block. Holds the
//             element width, the +0 encoding, the window-position width and
//             the IDLE/EMIT state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package max_unpool_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int POS_W      = 2;

  localparam logic [15:0]      FP16_POS_ZERO = 16'h0000;
  // Position of the last beat of a 2x2 window.
  localparam logic [POS_W-1:0] POS_LAST      = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

endpackage : max_unpool_pkg
`default_nettype wire

// File: rtl/max_unpool.sv
`default_nettype none
// ============================================================================
//  Module   : max_unpool
//  Purpose  : 2x2 max-unpool. Takes one pooled fp16 value plus the argmax
//             index of its 2x2 window. It then emits four beats (positions
//             0..3). The stored value appears at the argmax position and +0
//             at the other three.
//  Ports    : clk, rst                    - clock, synchronous active-high reset
//             in_valid/in_ready           - window handshake
//             in_value[DATA_WIDTH], in_idx[2] - pooled value and argmax position
//             out_valid/out_ready         - beat handshake
//             out_data[DATA_WIDTH], out_pos[2], out_last - beat payload
//  Revision : 1.0 - initial release
// ============================================================================
module max_unpool #(
  parameter int DATA_WIDTH = max_unpool_pkg::DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_value,
  input  logic [max_unpool_pkg::POS_W-1:0]  in_idx,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [max_unpool_pkg::POS_W-1:0]  out_pos,
  output logic                              out_last
);

  import max_unpool_pkg::*;

  localparam logic [DATA_WIDTH-1:0] C_ZERO = DATA_WIDTH'(FP16_POS_ZERO);

  state_e                state_q, state_d;
  logic [POS_W-1:0]      cnt_q,   cnt_d;
  logic [POS_W-1:0]      idx_q,   idx_d;
  logic [DATA_WIDTH-1:0] val_q,   val_d;

  logic final_beat;
  logic accept;
  logic beat_hs;

  always_comb begin
    final_beat = (state_q == ST_EMIT) && (cnt_q == POS_LAST);

    // Handshake outputs are forced low during reset. This keeps a window that
    // is in flight from producing beats or accepting new input.
    in_ready  = !rst && ((state_q == ST_IDLE) || (final_beat && out_ready));
    out_valid = !rst && (state_q == ST_EMIT);

    accept  = in_valid && in_ready;
    beat_hs = out_valid && out_ready;

    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    val_d   = val_q;

    if (accept) begin
      val_d = in_value;
      idx_d = in_idx;
    end

    // A 2-bit counter wraps 3->0 by itself on the final handshake.
    if (beat_hs) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        // A window accepted on the final beat continues in EMIT with no
        // bubble between windows.
        if (beat_hs && (cnt_q == POS_LAST)) begin
          state_d = accept ? ST_EMIT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (out_valid) begin
      out_pos  = cnt_q;
      out_last = (cnt_q == POS_LAST);
      out_data = (cnt_q == idx_q) ? val_q : C_ZERO;
    end else begin
      out_pos  = '0;
      out_last = 1'b0;
      out_data = C_ZERO;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
    end
  end

endmodule : max_unpool
`default_nettype wire

// File: tb/tb_max_unpool.sv
`default_nettype none
// ============================================================================
//  Module   : tb_max_unpool
//  Purpose  : Self-checking bench for max_unpool. It runs table-driven
//             single windows, hand-written multi-cycle sequences (back-to-back,
//             stall and mid-window reset) and a randomized phase. A
//             window-queue reference model checks every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_max_unpool;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_value;
  logic [1:0]  in_idx;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_pos;
  logic        out_last;

  int n_checks = 0;
  int n_fail   = 0;

  max_unpool #(.DATA_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_idx    (in_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_pos   (out_pos),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a queue of accepted windows. Each window unpools to four
  // beats. Beat p carries the value when p equals the argmax index, else +0.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [15:0] v;
    logic [1:0]  idx;
  } win_t;

  win_t        mq[$];
  int          mbeat      = 0;
  bit          prev_stall = 0;
  logic [15:0] pd;
  logic [1:0]  pp;
  logic        pl;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_pos",   32'(out_pos),   32'd0);
      check("rst_out_last",  32'(out_last),  32'd0);
      mq.delete();
      mbeat      = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data",  32'(out_data),  32'(pd));
        check("hold_pos",   32'(out_pos),   32'(pp));
        check("hold_last",  32'(out_last),  32'(pl));
      end
      check("model_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("model_in_ready",  32'(in_ready),
            32'((mq.size() == 0) || (mbeat == 3 && out_ready)));
      if (out_valid && out_ready && mq.size() != 0) begin
        check("model_data", 32'(out_data),
              32'((mbeat == int'(mq[0].idx)) ? mq[0].v : 16'h0000));
        check("model_pos",  32'(out_pos),  32'(mbeat));
        check("model_last", 32'(out_last), 32'(mbeat == 3));
        if (mbeat == 3) begin
          void'(mq.pop_front());
          mbeat = 0;
        end else begin
          mbeat++;
        end
      end
      if (in_valid && in_ready) mq.push_back('{v: in_value, idx: in_idx});
      prev_stall = out_valid && !out_ready;
      pd = out_data;
      pp = out_pos;
      pl = out_last;
    end
  end

  // --------------------------------------------------------------------------
  // Directed helpers
  // --------------------------------------------------------------------------
  typedef struct {
    logic [15:0]      v;
    logic [1:0]       idx;
    logic [3:0][15:0] exp;   // exp[b] is the expected data of beat b
  } vec_t;

  vec_t tbl[5];

  // Waits (bounded) for in_ready at a negedge with in_valid held high.
  task automatic wait_accept(input string name);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check(name, 32'(k < 20), 32'd1);
  endtask

  task automatic run_window(input vec_t t);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_value  = t.v;
    in_idx    = t.idx;
    out_ready = 1'b1;
    wait_accept("win_accept_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_value = 16'($urandom);
    in_idx   = 2'($urandom);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check("win_valid", 32'(out_valid), 32'd1);
      check("win_data",  32'(out_data),  32'(t.exp[b]));
      check("win_pos",   32'(out_pos),   32'(b));
      check("win_last",  32'(out_last),  32'(b == 3));
    end
    @(negedge clk);
    check("win_end_idle", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp8 [8];
    logic [15:0] got  [4];
    logic [6:0]  pat;
    int          n;

    tbl[0].v = 16'h3C00; tbl[0].idx = 2'd2; tbl[0].exp = {16'h0000, 16'h3C00, 16'h0000, 16'h0000};
    tbl[1].v = 16'h7E01; tbl[1].idx = 2'd0; tbl[1].exp = {16'h0000, 16'h0000, 16'h0000, 16'h7E01};
    tbl[2].v = 16'h8000; tbl[2].idx = 2'd0; tbl[2].exp = {16'h0000, 16'h0000, 16'h0000, 16'h8000};
    tbl[3].v = 16'h7C00; tbl[3].idx = 2'd3; tbl[3].exp = {16'h7C00, 16'h0000, 16'h0000, 16'h0000};
    tbl[4].v = 16'h0001; tbl[4].idx = 2'd1; tbl[4].exp = {16'h0000, 16'h0000, 16'h0001, 16'h0000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_value  = 16'h0;
    in_idx    = 2'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready",  32'(in_ready),  32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Table-driven single windows
    for (int i = 0; i < 5; i++) run_window(tbl[i]);

    // Back-to-back windows with in_valid held high
    exp8 = '{16'h0000, 16'h0000, 16'h0000, 16'hC000,
             16'h0000, 16'h0001, 16'h0000, 16'h0000};
    @(posedge clk); #1;
    in_valid = 1'b1; in_value = 16'hC000; in_idx = 2'd3; out_ready = 1'b1;
    wait_accept("b2b_accept_timeout");
    @(posedge clk); #1;
    in_value = 16'h0001; in_idx = 2'd1;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      check("b2b_valid",    32'(out_valid), 32'd1);
      check("b2b_data",     32'(out_data),  32'(exp8[b]));
      check("b2b_pos",      32'(out_pos),   32'(b % 4));
      check("b2b_in_ready", 32'(in_ready),  32'(b % 4 == 3));
      if (b == 3) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_end_idle", 32'(out_valid), 32'd0);

    // Stall pattern 1,0,0,1,0,1,1 on out_ready
    pat = 7'b1101001;   // bit c is the out_ready value for cycle c
    @(posedge clk); #1;
    in_valid = 1'b1; in_value = 16'h4500; in_idx = 2'd1; out_ready = 1'b1;
    wait_accept("stall_accept_timeout");
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = pat[0];
    n = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (out_valid && out_ready && n < 4) begin
        got[n] = out_data;
        n++;
      end
      @(posedge clk); #1;
      out_ready = (c < 6) ? pat[c+1] : 1'b1;
    end
    check("stall_beats", 32'(n), 32'd4);
    check("stall_b0", 32'(got[0]), 32'h0000);
    check("stall_b1", 32'(got[1]), 32'h4500);
    check("stall_b2", 32'(got[2]), 32'h0000);
    check("stall_b3", 32'(got[3]), 32'h0000);
    @(negedge clk);
    check("stall_end_idle", 32'(out_valid), 32'd0);

    // Reset after beat 1 of a window
    @(posedge clk); #1;
    in_valid = 1'b1; in_value = 16'h1234; in_idx = 2'd2; out_ready = 1'b1;
    wait_accept("rstmid_accept_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rstmid_pos0", 32'(out_pos), 32'd0);
    @(negedge clk);
    check("rstmid_pos1", 32'(out_pos), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_valid",    32'(out_valid), 32'd0);
    check("rstmid_in_ready", 32'(in_ready),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_idle_valid", 32'(out_valid), 32'd0);
    check("rstmid_idle_ready", 32'(in_ready),  32'd1);
    run_window(tbl[0]);

    // Randomized traffic checked by the reference model
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_value  = 16'($urandom);
      in_idx    = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("drain_model_empty", 32'(mq.size()), 32'd0);
    check("drain_idle",        32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_max_unpool
`default_nettype wire
